// File: rtl/argmax_stream.sv
// Streaming argmax over N IEEE-754 single-precision elements per vector.
// Optional NaN filtering is enabled by defining ARGMAX_NAN_FILTER_EN.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   ACC   | accepting elements, tracking running max/index
//   OUT   | result held on output_max/output_index until handshake
module argmax_stream #(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             input_valid,
  input  logic [31:0]      input_x,
  output logic             input_ready,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [31:0]      output_max,
  output logic [IDX_W-1:0] output_index
);

  typedef enum logic {ACC = 1'b0, OUT = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [31:0]      run_max;
  logic [IDX_W-1:0] run_idx;

  logic             accept;
  logic             first;
  logic             last;
  logic             take;
  logic [1:0]       cmp;
  logic [31:0]      next_max;
  logic [IDX_W-1:0] next_idx;

  // Map a float onto an unsigned key whose integer order matches the
  // sign/exponent/mantissa order (+0 above -0, +NaN above +Inf, -NaN below -Inf).
  function automatic logic [31:0] order_key(input logic [31:0] x);
    return x[31] ? {1'b0, ~x[30:0]} : {1'b1, x[30:0]};
  endfunction

  // 2'b10: a > b, 2'b01: a < b, 2'b00: identical bit patterns.
  function automatic logic [1:0] fcmp(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka;
    logic [31:0] kb;
    ka = order_key(a);
    kb = order_key(b);
    if (ka > kb)      return 2'b10;
    else if (ka < kb) return 2'b01;
    else              return 2'b00;
  endfunction

`ifdef ARGMAX_NAN_FILTER_EN
  logic run_nan;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction
`endif

  always_comb begin
    accept = input_valid && input_ready;
    first  = (cnt == '0);
    last   = (cnt == IDX_W'(N - 1));
    cmp    = fcmp(input_x, run_max);
`ifdef ARGMAX_NAN_FILTER_EN
    // A NaN held from element 0 yields to the first real number.
    take   = first || (!is_nan(input_x) && (run_nan || (cmp == 2'b10)));
`else
    take   = first || (cmp == 2'b10);
`endif
    next_max = take ? input_x : run_max;
    next_idx = take ? cnt : run_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ACC;
      cnt          <= '0;
      run_max      <= 32'h0;
      run_idx      <= '0;
      input_ready  <= 1'b1;
      output_valid <= 1'b0;
      output_max   <= 32'h0;
      output_index <= '0;
`ifdef ARGMAX_NAN_FILTER_EN
      run_nan      <= 1'b0;
`endif
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            run_max <= next_max;
            run_idx <= next_idx;
`ifdef ARGMAX_NAN_FILTER_EN
            if (take) run_nan <= is_nan(input_x);
`endif
            if (last) begin
              cnt          <= '0;
              output_max   <= next_max;
              output_index <= next_idx;
              state        <= OUT;
              input_ready  <= 1'b0;
              output_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        OUT: begin
          if (output_ready) begin
            state        <= ACC;
            output_valid <= 1'b0;
            input_ready  <= 1'b1;
          end
        end
        default: begin
          state        <= ACC;
          input_ready  <= 1'b1;
          output_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench for argmax_stream (N=4): directed vectors push expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_argmax_stream;
  localparam int N     = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             input_valid = 1'b0;
  logic [31:0]      input_x = 32'h0;
  logic             input_ready;
  logic             output_valid;
  logic             output_ready = 1'b0;
  logic [31:0]      output_max;
  logic [IDX_W-1:0] output_index;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];

  argmax_stream #(.N(N), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_valid  (input_valid),
    .input_x      (input_x),
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_max   (output_max),
    .output_index (output_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && output_valid && output_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got max %h idx %0d expected none", output_max, output_index);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("result_max", output_max, e[33:2]);
        check("result_index", {30'b0, output_index}, {30'b0, e[1:0]});
      end
    end
  end

  task automatic send1(input logic [31:0] x);
    int n;
    n = 0;
    input_valid = 1'b1;
    input_x = x;
    while (!input_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got input_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  task automatic send4(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    send1(a);
    send1(b);
    send1(c);
    send1(d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_input_ready", {31'b0, input_ready}, 32'h1);
    check("reset_output_valid", {31'b0, output_valid}, 32'h0);
    check("reset_output_max", output_max, 32'h0);
    check("reset_output_index", {30'b0, output_index}, 32'h0);
    rst_n = 1'b1;
    output_ready = 1'b1;

    // 1.0, 3.0, 2.0, -5.0 -> 3.0 at index 1, valid for exactly one cycle
    exp_q.push_back({32'h40400000, 2'd1});
    send4(32'h3F800000, 32'h40400000, 32'h40000000, 32'hC0A00000);
    check("vecA_valid_now", {31'b0, output_valid}, 32'h1);
    @(posedge clk);
    #1;
    check("vecA_valid_dropped", {31'b0, output_valid}, 32'h0);
    check("vecA_ready_back", {31'b0, input_ready}, 32'h1);

    // tie keeps the first index
    exp_q.push_back({32'h40000000, 2'd0});
    send4(32'h40000000, 32'h40000000, 32'hBF800000, 32'h40000000);

    // +0 ranks above -0
    exp_q.push_back({32'h00000000, 2'd1});
    send4(32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000);
    drain();

    // back-pressure: result held, input ignored for 5 cycles
    output_ready = 1'b0;
    exp_q.push_back({32'h40E00000, 2'd2});
    send4(32'h3FC00000, 32'hBF800000, 32'h40E00000, 32'h40E00000);
    for (int i = 0; i < 5; i++) begin
      input_valid = 1'b1;
      input_x = 32'h7F000000;
      check("stall_input_ready", {31'b0, input_ready}, 32'h0);
      check("stall_output_valid", {31'b0, output_valid}, 32'h1);
      check("stall_output_max", output_max, 32'h40E00000);
      check("stall_output_index", {30'b0, output_index}, 32'h2);
      @(posedge clk);
      #1;
    end
    input_valid = 1'b0;
    output_ready = 1'b1;
    exp_q.push_back({32'h3F000000, 2'd1});
    send4(32'h3E800000, 32'h3F000000, 32'h3E000000, 32'hBF800000);
    drain();

    // reset while holding a result drops it
    output_ready = 1'b0;
    send4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    check("out_before_reset_valid", {31'b0, output_valid}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("out_reset_valid", {31'b0, output_valid}, 32'h0);
    check("out_reset_ready", {31'b0, input_ready}, 32'h1);
    check("out_reset_max", output_max, 32'h0);
    output_ready = 1'b1;

    // reset mid-vector discards 100.0 and 50.0
    send1(32'h42C80000);
    send1(32'h42480000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back({32'h40800000, 2'd2});
    send4(32'h3F000000, 32'h3E800000, 32'h40800000, 32'h3F800000);

    // NaN at element 0
`ifdef ARGMAX_NAN_FILTER_EN
    exp_q.push_back({32'h3F800000, 2'd1});
`else
    exp_q.push_back({32'h7FC00000, 2'd0});
`endif
    send4(32'h7FC00000, 32'h3F800000, 32'hC0400000, 32'h3F000000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
